ln4017_seq_ctrl: RTL and testbench
==================================

// Module: ln4017_seq_ctrl
// PURPOSE
//  Sequencer for an external 4017-style decade counter/decoder. Drives its cp0/cp1/mr pins to step
//  through N of 10 one-hot stages, holding each stage for a programmable dwell time.
//  Runs one-shot or looped, and optionally checks the counter's out_q feedback.
//  Sits between control logic and the counter model; outputs wire directly to cp0, cp1 and mr.
// PARAMETERS
//  DWELL_W   8   width of dwell input/counter
// PORTS
//  cp0       in   1        clock, rising edge
//  mr_n      in   1        asynchronous active-low reset
//  start     in   1        level; sampled each cycle; begins a run from IDLE/DONE
//  stop      in   1        level; aborts a run
//  loop      in   1        latched at start: 1 = restart after last stage, 0 = one-shot
//  len       in   4        stages per run N; latched at start; clamped to 2..10
//  dwell     in   DWELL_W  DWELL cycles per stage minus 1; latched at start
//  cnt_q     in   10       counter out_q feedback
//  cnt_cp0   out  1        step pulse to counter cp0
//  cnt_cp1   out  1        counter inhibit (1 = inhibit)
//  cnt_mr    out  1        counter master reset, active high
//  stage     out  4        binary index of current stage, 0..N-1
//  busy      out  1        1 in CLEAR/CHECK/DWELL/STEP
//  done      out  1        1 in DONE
//  fault     out  1        1 in FAULT
// BEHAVIOUR
//  - All outputs registered, decoded from next state. Reset values: cnt_cp0=0, cnt_cp1=1, cnt_mr=1,
//    stage=0, busy=0, done=0, fault=0, state=IDLE.
//  - cnt_mr falls on the first cp0 edge after mr_n releases.
//  - States: IDLE, CLEAR, CHECK, DWELL, STEP, DONE, FAULT.
//  - IDLE/DONE: cnt_cp1=1, cnt_cp0=0, cnt_mr=0.
//    start&!stop -> CLEAR. len, dwell and loop are latched; stage=0.
//  - CLEAR (1 cycle): cnt_mr=1, cnt_cp1=1 -> CHECK.
//  - STEP (1 cycle): cnt_cp1=0, cnt_cp0=1 (one rising edge to counter); stage+1 -> CHECK.
//  - CHECK (1 cycle): cnt_cp0=0, cnt_cp1=0. With check enabled, mismatch of
//    cnt_q vs (10'b1<<stage) -> FAULT; else -> DWELL.
//  - DWELL: cnt_cp1=0. Internal counter runs 0..dwell (dwell+1 cycles). At terminal:
//      stage<N-1 -> STEP
//      stage==N-1 & loop -> CLEAR
//      stage==N-1 & !loop -> DONE
//  - Per-stage period: dwell+3 cycles (STEP+CHECK+DWELL). First stage: CLEAR+CHECK+dwell+1.
//  - stop in any busy state -> IDLE on next edge; counter contents are left intact.
//    stop beats start in the same cycle. start while busy is ignored.
//  - FAULT: cnt_cp1=1, fault=1. Exit only on start (-> CLEAR, fault clears) or reset.
//  - Clamping: len<2 -> 2, len>10 -> 10.
//  - mr_n low mid-run: outputs return to reset values immediately (async).
// CONFIGURATION
//  LN4017_CHECK_EN defined: CHECK compares cnt_q as above; FAULT is reachable.
//  Not defined: cnt_q is ignored, CHECK always -> DWELL, fault tied 0, FAULT unreachable.
//  Timing is identical either way.
// TESTING
//  1. Reset, len=4, dwell=2, loop=0, pulse start
//     -> cnt_mr high 1 cycle; stages 0,1,2,3 each 5 cycles after the first; then done=1.
//  2. len=10, dwell=0, loop=1, with counter model attached
//     -> continuous cycling; stage 9 -> CLEAR; fault stays 0 over 3 loops.
//  3. stop asserted during DWELL of stage 2 -> IDLE next edge; busy=0, cnt_cp1=1;
//     counter holds out_q=10'b100.
//  4. len=15 -> runs 10 stages. len=0 -> runs 2 stages.
//  5. LN4017_CHECK_EN: force cnt_q=0 after a STEP -> FAULT; fault=1, cnt_cp1=1.
//     start -> fault=0, CLEAR.
//  6. mr_n low mid-STEP -> cnt_cp0=0, cnt_mr=1, state IDLE at once.
//     Release mr_n -> cnt_mr=0 after one edge.

Source files
------------

// File: rtl/ln4017_seq_ctrl_if.sv
// ----------------------------------------------------------------------------
// ln4017_seq_ctrl_if
//   Bundles the control-side and counter-side signals of the 4017 sequencer.
//   The sequencer sits on the slave modport. The environment (control logic
//   plus the external 4017 counter) sits on the master modport.
//
//   Control side : start, stop, loop, len[3:0], dwell[DWELL_W-1:0]  (to sequencer)
//                  stage[3:0], busy, done, fault                     (from sequencer)
//   Counter side : cnt_q[9:0]                                        (to sequencer)
//                  cnt_cp0, cnt_cp1, cnt_mr                          (from sequencer)
// ----------------------------------------------------------------------------
interface ln4017_seq_ctrl_if #(
    parameter int DWELL_W = 8
) ();
    logic               start;
    logic               stop;
    logic               loop;
    logic [3:0]         len;
    logic [DWELL_W-1:0] dwell;
    logic [9:0]         cnt_q;
    logic               cnt_cp0;
    logic               cnt_cp1;
    logic               cnt_mr;
    logic [3:0]         stage;
    logic               busy;
    logic               done;
    logic               fault;

    modport master (
        output start, stop, loop, len, dwell, cnt_q,
        input  cnt_cp0, cnt_cp1, cnt_mr, stage, busy, done, fault
    );

    modport slave (
        input  start, stop, loop, len, dwell, cnt_q,
        output cnt_cp0, cnt_cp1, cnt_mr, stage, busy, done, fault
    );
endinterface

// File: rtl/ln4017_seq_ctrl.sv
// ----------------------------------------------------------------------------
// ln4017_seq_ctrl
//   Sequencer for an external 4017-style decade counter/decoder. Drives the
//   counter's cp0 (step), cp1 (inhibit) and mr (master reset) pins to walk
//   through N of the 10 one-hot stages, holding each for dwell+1 cycles.
//   Runs one-shot or looped. Stage timing: CLEAR, CHECK, DWELL for the first
//   stage, then STEP, CHECK, DWELL (dwell+3 cycles) for each further stage.
//
// Ports
//   cp0_i   : clock, rising edge
//   mr_n_i  : asynchronous active-low reset
//   bus     : ln4017_seq_ctrl_if.slave (control inputs, counter feedback,
//             counter pin drives and status outputs)
//
// Configuration
//   LN4017_CHECK_EN : when defined, CHECK compares cnt_q against the expected
//                     one-hot stage and enters FAULT on a mismatch. When not
//                     defined, cnt_q is ignored and fault is tied low. Timing
//                     is the same in both builds.
// ----------------------------------------------------------------------------
module ln4017_seq_ctrl #(
    parameter int DWELL_W = 8
) (
    input  logic                cp0_i,
    input  logic                mr_n_i,
    ln4017_seq_ctrl_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_CHECK,
        S_DWELL,
        S_STEP,
        S_DONE,
        S_FAULT
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         stage_q, stage_d;
    logic [3:0]         len_q, len_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               loop_q, loop_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;

    logic cnt_cp0_q, cnt_cp0_d;
    logic cnt_cp1_q, cnt_cp1_d;
    logic cnt_mr_q,  cnt_mr_d;
    logic busy_q,    busy_d;
    logic done_q,    done_d;
    logic fault_q,   fault_d;

    logic chk_fail;
    logic busy_now;

    function automatic logic [3:0] clamp_len(input logic [3:0] l);
        if (l < 4'd2) begin
            return 4'd2;
        end else if (l > 4'd10) begin
            return 4'd10;
        end
        return l;
    endfunction

`ifdef LN4017_CHECK_EN
    // Counter must show exactly the bit for the stage we believe we are in.
    assign chk_fail = (bus.cnt_q != (10'b1 << stage_q));
`else
    logic unused_cnt_q;
    assign unused_cnt_q = ^bus.cnt_q;
    assign chk_fail     = 1'b0;
`endif

    assign busy_now = (state_q == S_CLEAR) || (state_q == S_CHECK) ||
                      (state_q == S_DWELL) || (state_q == S_STEP);

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        len_d       = len_q;
        dwell_d     = dwell_q;
        loop_d      = loop_q;
        dwell_cnt_d = dwell_cnt_q;

        case (state_q)
            S_IDLE, S_DONE, S_FAULT: begin
                if (bus.start && !bus.stop) begin
                    state_d     = S_CLEAR;
                    len_d       = clamp_len(bus.len);
                    dwell_d     = bus.dwell;
                    loop_d      = bus.loop;
                    stage_d     = 4'd0;
                    dwell_cnt_d = '0;
                end
            end
            S_CLEAR: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                dwell_cnt_d = '0;
                state_d     = chk_fail ? S_FAULT : S_DWELL;
            end
            S_DWELL: begin
                if (dwell_cnt_q == dwell_q) begin
                    dwell_cnt_d = '0;
                    if (stage_q < (len_q - 4'd1)) begin
                        state_d = S_STEP;
                    end else if (loop_q) begin
                        state_d = S_CLEAR;
                        stage_d = 4'd0;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    dwell_cnt_d = dwell_cnt_q + 1'b1;
                end
            end
            S_STEP: begin
                stage_d = stage_q + 4'd1;
                state_d = S_CHECK;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything else; counter pins go to hold so the
        // counter keeps whatever stage it was showing.
        if (busy_now && bus.stop) begin
            state_d     = S_IDLE;
            stage_d     = stage_q;
            dwell_cnt_d = '0;
        end
    end

    // Output decode from the next state so the pins are registered yet
    // line up with the state they belong to.
    always_comb begin
        cnt_cp0_d = 1'b0;
        cnt_cp1_d = 1'b1;
        cnt_mr_d  = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        fault_d   = 1'b0;
        case (state_d)
            S_CLEAR: begin
                cnt_mr_d = 1'b1;
                busy_d   = 1'b1;
            end
            S_CHECK: begin
                cnt_cp1_d = 1'b0;
                busy_d    = 1'b1;
            end
            S_DWELL: begin
                cnt_cp1_d = 1'b0;
                busy_d    = 1'b1;
            end
            S_STEP: begin
                cnt_cp0_d = 1'b1;
                cnt_cp1_d = 1'b0;
                busy_d    = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            S_FAULT: begin
`ifdef LN4017_CHECK_EN
                fault_d = 1'b1;
`else
                fault_d = 1'b0;
`endif
            end
            default: begin
                cnt_cp1_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge cp0_i or negedge mr_n_i) begin
        if (!mr_n_i) begin
            state_q     <= S_IDLE;
            stage_q     <= 4'd0;
            len_q       <= 4'd2;
            dwell_q     <= '0;
            loop_q      <= 1'b0;
            dwell_cnt_q <= '0;
            cnt_cp0_q   <= 1'b0;
            cnt_cp1_q   <= 1'b1;
            cnt_mr_q    <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            len_q       <= len_d;
            dwell_q     <= dwell_d;
            loop_q      <= loop_d;
            dwell_cnt_q <= dwell_cnt_d;
            cnt_cp0_q   <= cnt_cp0_d;
            cnt_cp1_q   <= cnt_cp1_d;
            cnt_mr_q    <= cnt_mr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
        end
    end

    assign bus.cnt_cp0 = cnt_cp0_q;
    assign bus.cnt_cp1 = cnt_cp1_q;
    assign bus.cnt_mr  = cnt_mr_q;
    assign bus.stage   = stage_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.fault   = fault_q;

endmodule

// File: tb/tb_ln4017_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ln4017_seq_ctrl
//   Bench for ln4017_seq_ctrl with a behavioural 4017 counter on the counter
//   pins. Run configurations and their hand-computed results sit in a table;
//   looping, stop, fault/check and async reset are hand-written sequences.
//   LN4017_CHECK_EN selects which fault behaviour is expected.
// ----------------------------------------------------------------------------
module tb_ln4017_seq_ctrl;

    logic clk;
    logic mr_n;
    logic [9:0] model_q;
    logic force_zero;

    int n_cmp;
    int n_bad;

    ln4017_seq_ctrl_if #(.DWELL_W(8)) bus ();

    ln4017_seq_ctrl #(.DWELL_W(8)) dut (
        .cp0_i  (clk),
        .mr_n_i (mr_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 4017 model: mr resets to stage 0, cp0 rising edge advances unless inhibited.
    always @(posedge bus.cnt_cp0 or posedge bus.cnt_mr) begin
        if (bus.cnt_mr) begin
            model_q <= 10'b1;
        end else if (!bus.cnt_cp1) begin
            model_q <= {model_q[8:0], model_q[9]};
        end
    end

    assign bus.cnt_q = force_zero ? 10'b0 : model_q;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] len;
        logic [7:0] dwell;
        bit         mid_start;
        int         exp_n;
        int         exp_cyc;
    } vec_t;

    vec_t vec [7];

    initial begin
        int n;
        int mr_cnt;
        int cp0_cnt;
        int max_stage;
        int bad_fb;
        int guard;
        int st_at [0:20];
        int cp_at [0:20];

        // {len, dwell, mid_start, clamped N, cycles from start edge to done}
        // cycles = 2 + (dwell+1) + (N-1)*(dwell+3)
        vec[0] = '{4'd4,  8'd2, 1'b0, 4,  20};
        vec[1] = '{4'd15, 8'd0, 1'b0, 10, 30};
        vec[2] = '{4'd0,  8'd1, 1'b0, 2,  8};
        vec[3] = '{4'd1,  8'd3, 1'b1, 2,  12};
        vec[4] = '{4'd10, 8'd0, 1'b0, 10, 30};
        vec[5] = '{4'd2,  8'd0, 1'b1, 2,  6};
        vec[6] = '{4'd7,  8'd5, 1'b0, 7,  56};

        n_cmp = 0;
        n_bad = 0;
        force_zero = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.loop  = 1'b0;
        bus.len   = 4'd4;
        bus.dwell = 8'd2;

        // Reset state
        mr_n = 1'b0;
        #13;
        chk("rst_cp0",   int'(bus.cnt_cp0), 0);
        chk("rst_cp1",   int'(bus.cnt_cp1), 1);
        chk("rst_mr",    int'(bus.cnt_mr),  1);
        chk("rst_stage", int'(bus.stage),   0);
        chk("rst_busy",  int'(bus.busy),    0);
        chk("rst_done",  int'(bus.done),    0);
        chk("rst_fault", int'(bus.fault),   0);
        mr_n = 1'b1;
        step();
        chk("rel_mr",    int'(bus.cnt_mr),  0);
        chk("rel_cp1",   int'(bus.cnt_cp1), 1);

        // Hand sequence: len=4 dwell=2 one-shot, stage boundaries
        bus.len = 4'd4; bus.dwell = 8'd2; bus.loop = 1'b0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        st_at[0] = int'(bus.stage);
        cp_at[0] = int'(bus.cnt_cp0);
        chk("t1_mr_first", int'(bus.cnt_mr), 1);
        for (int i = 1; i <= 20; i++) begin
            step();
            st_at[i] = int'(bus.stage);
            cp_at[i] = int'(bus.cnt_cp0);
            if (i == 1) chk("t1_mr_one_cycle", int'(bus.cnt_mr), 0);
        end
        chk("t1_stage_n5",  st_at[5],  0);
        chk("t1_cp0_n5",    cp_at[5],  1);
        chk("t1_stage_n6",  st_at[6],  1);
        chk("t1_cp0_n10",   cp_at[10], 1);
        chk("t1_stage_n11", st_at[11], 2);
        chk("t1_stage_n16", st_at[16], 3);
        chk("t1_cp0_n19",   cp_at[19], 0);
        chk("t1_done",      int'(bus.done), 1);
        chk("t1_cnt_q",     int'(model_q), 10'b1000);

        // Table-driven one-shot runs
        for (int v = 0; v < 7; v++) begin
            bus.len = vec[v].len; bus.dwell = vec[v].dwell; bus.loop = 1'b0;
            bus.start = 1'b1;
            step();
            bus.start = 1'b0;
            n = 0;
            mr_cnt = int'(bus.cnt_mr);
            cp0_cnt = 0;
            max_stage = int'(bus.stage);
            bad_fb = 0;
            while (!bus.done && n < 300) begin
                bus.start = (vec[v].mid_start && n == 3);
                step();
                n++;
                mr_cnt  += int'(bus.cnt_mr);
                cp0_cnt += int'(bus.cnt_cp0);
                if (int'(bus.stage) > max_stage) max_stage = int'(bus.stage);
                if (bus.busy && !bus.cnt_mr && !bus.cnt_cp0 &&
                    model_q != (10'b1 << bus.stage)) bad_fb++;
            end
            bus.start = 1'b0;
            chk($sformatf("v%0d_done_cycle", v), n, vec[v].exp_cyc);
            chk($sformatf("v%0d_mr_cycles", v), mr_cnt, 1);
            chk($sformatf("v%0d_steps", v), cp0_cnt, vec[v].exp_n - 1);
            chk($sformatf("v%0d_last_stage", v), max_stage, vec[v].exp_n - 1);
            chk($sformatf("v%0d_feedback", v), bad_fb, 0);
            chk($sformatf("v%0d_cnt_q", v), int'(model_q), 1 << (vec[v].exp_n - 1));
            chk($sformatf("v%0d_cp1_done", v), int'(bus.cnt_cp1), 1);
        end

        // Looped run: len=10 dwell=0, three full loops plus a little
        bus.len = 4'd10; bus.dwell = 8'd0; bus.loop = 1'b1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        mr_cnt = int'(bus.cnt_mr);
        cp0_cnt = 0; bad_fb = 0; max_stage = 0;
        guard = 0;
        for (int i = 1; i <= 95; i++) begin
            step();
            mr_cnt  += int'(bus.cnt_mr);
            cp0_cnt += int'(bus.cnt_cp0);
            if (int'(bus.stage) > max_stage) max_stage = int'(bus.stage);
            if (bus.fault || bus.done || !bus.busy) guard++;
            if (!bus.cnt_mr && !bus.cnt_cp0 && model_q != (10'b1 << bus.stage)) bad_fb++;
        end
        chk("loop_clears", mr_cnt, 4);
        chk("loop_steps", cp0_cnt, 28);
        chk("loop_max_stage", max_stage, 9);
        chk("loop_never_idle", guard, 0);
        chk("loop_feedback", bad_fb, 0);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        chk("loop_stop_busy", int'(bus.busy), 0);
        chk("loop_stop_cnt_q", int'(model_q), 10'b10);

        // Stop during DWELL of stage 2
        bus.len = 4'd4; bus.dwell = 8'd2; bus.loop = 1'b0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 1; i <= 12; i++) step();
        chk("stop_pre_stage", int'(bus.stage), 2);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        chk("stop_busy", int'(bus.busy), 0);
        chk("stop_cp1", int'(bus.cnt_cp1), 1);
        chk("stop_mr", int'(bus.cnt_mr), 0);
        chk("stop_done", int'(bus.done), 0);
        chk("stop_cnt_q", int'(model_q), 10'b100);
        step(); step();
        chk("stop_hold_cnt_q", int'(model_q), 10'b100);
        bus.start = 1'b1; bus.stop = 1'b1;
        step();
        chk("stop_beats_start", int'(bus.busy), 0);
        bus.start = 1'b0; bus.stop = 1'b0;

        // Corrupt counter feedback right after a STEP
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        guard = 0;
        while (!bus.cnt_cp0 && guard < 50) begin
            step();
            guard++;
        end
        chk("fault_found_step", int'(bus.cnt_cp0), 1);
        force_zero = 1'b1;
        step();
        step();
`ifdef LN4017_CHECK_EN
        chk("fault_set", int'(bus.fault), 1);
        chk("fault_cp1", int'(bus.cnt_cp1), 1);
        chk("fault_busy", int'(bus.busy), 0);
        force_zero = 1'b0;
        step();
        chk("fault_sticky", int'(bus.fault), 1);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("fault_clear", int'(bus.fault), 0);
        chk("fault_restart_mr", int'(bus.cnt_mr), 1);
        chk("fault_restart_busy", int'(bus.busy), 1);
`else
        chk("nocheck_fault", int'(bus.fault), 0);
        chk("nocheck_busy", int'(bus.busy), 1);
        chk("nocheck_cp1", int'(bus.cnt_cp1), 0);
        force_zero = 1'b0;
`endif

        // Async reset in the middle of a STEP
        guard = 0;
        while (!bus.cnt_cp0 && guard < 50) begin
            step();
            guard++;
        end
        chk("mrn_found_step", int'(bus.cnt_cp0), 1);
        #2 mr_n = 1'b0;
        #1;
        chk("mrn_cp0", int'(bus.cnt_cp0), 0);
        chk("mrn_mr", int'(bus.cnt_mr), 1);
        chk("mrn_cp1", int'(bus.cnt_cp1), 1);
        chk("mrn_busy", int'(bus.busy), 0);
        #2 mr_n = 1'b1;
        #1;
        chk("mrn_mr_held", int'(bus.cnt_mr), 1);
        step();
        chk("mrn_rel_mr", int'(bus.cnt_mr), 0);
        chk("mrn_rel_busy", int'(bus.busy), 0);
        chk("mrn_rel_cp1", int'(bus.cnt_cp1), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
